// File: rtl/bus_mem_slave.sv
// Byte-lane memory slave for the multiplexed ALE/RD_N/WR_N/IOM CPU bus, with READY wait-state insertion.
// Define BUS_MEM_PARITY_EN to store one even-parity bit per byte and report mismatches on PERR.
module bus_mem_slave #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 20,
    parameter int                DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = {ADDR_W{1'b0}},
    parameter int                WAIT_STATES = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  ALE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic                  IOM,
    input  logic [DATA_W/8-1:0]   BE_N,
    input  logic                  RD_N,
    input  logic                  WR_N,
    input  logic [DATA_W-1:0]     DIN,
    output logic [DATA_W-1:0]     DOUT,
    output logic                  DOUT_EN,
    output logic                  READY,
`ifdef BUS_MEM_PARITY_EN
    output logic                  PERR,
`endif
    output logic                  ERR
);
    localparam int              BYTES    = DATA_W / 8;
    localparam int              OFF_W    = $clog2(BYTES);
    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] WIN_SIZE = (ADDR_W + 1)'(DEPTH * BYTES);
    localparam logic [3:0]      WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_XFER = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_iom;
    logic [BYTES-1:0]    r_be_n;
    logic                r_dir_rd;
    logic [3:0]          r_cnt;
    logic                r_first;
    logic [DATA_W-1:0]   r_dout;
    logic                r_dout_en;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [ADDR_W:0]     w_diff;
    logic                w_sel;
    logic [IDX_W-1:0]    w_idx;
    logic                w_rd_req;
    logic                w_wr_req;
    logic                w_strobe_off;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   w_rd_masked;
    logic                w_we;
    logic                w_ready;

    // The extra top bit of the difference is the borrow: set when the address lies below the window.
    assign w_diff       = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    assign w_sel        = !r_iom && !w_diff[ADDR_W] && ({1'b0, w_diff[ADDR_W-1:0]} < WIN_SIZE);
    assign w_idx        = w_diff[OFF_W +: IDX_W];
    assign w_rd_req     = !RD_N && WR_N;
    assign w_wr_req     = RD_N && !WR_N;
    assign w_strobe_off = r_dir_rd ? RD_N : WR_N;
    assign w_rdata      = r_mem[w_idx];
    assign w_we         = (r_state == ST_XFER) && r_first && !r_dir_rd && !ALE;

    // Read data with disabled byte lanes forced to zero
    always_comb begin
        w_rd_masked = {DATA_W{1'b0}};
        for (int i = 0; i < BYTES; i++) begin
            if (!r_be_n[i]) begin
                w_rd_masked[8*i +: 8] = w_rdata[8*i +: 8];
            end else begin
                w_rd_masked[8*i +: 8] = 8'h00;
            end
        end
    end

    // READY drops as soon as a selected strobe is seen so the CPU inserts its first wait immediately
    always_comb begin
        if (r_state == ST_WAIT) begin
            w_ready = 1'b0;
        end else if ((r_state == ST_ADDR) && w_sel && (w_rd_req || w_wr_req) && (WAIT_STATES > 0)) begin
            w_ready = 1'b0;
        end else begin
            w_ready = 1'b1;
        end
    end

    // Array write on the first XFER edge only; contents are deliberately not reset
    always_ff @(posedge CLK) begin
        if (w_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (!r_be_n[i]) begin
                    r_mem[w_idx][8*i +: 8] <= DIN[8*i +: 8];
                end
            end
        end
    end

    // Bus-cycle FSM; ALE restarts the cycle from any state and overrides every other transition
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_addr    <= {ADDR_W{1'b0}};
            r_iom     <= 1'b0;
            r_be_n    <= {BYTES{1'b1}};
            r_dir_rd  <= 1'b0;
            r_cnt     <= 4'd0;
            r_first   <= 1'b0;
            r_dout    <= {DATA_W{1'b0}};
            r_dout_en <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (ALE) begin
                r_addr    <= ADDRESS;
                r_iom     <= IOM;
                r_be_n    <= BE_N;
                r_first   <= 1'b0;
                r_dout_en <= 1'b0;
                r_state   <= ST_ADDR;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_ADDR: begin
                        if (!w_sel) begin
                            r_state <= ST_IDLE;
                        end else if (!RD_N && !WR_N) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (w_rd_req || w_wr_req) begin
                            r_dir_rd <= w_rd_req;
                            if (WAIT_STATES > 0) begin
                                r_cnt   <= WS_LOAD;
                                r_state <= ST_WAIT;
                            end else begin
                                r_first <= 1'b1;
                                r_state <= ST_XFER;
                            end
                        end else begin
                            r_state <= ST_ADDR;
                        end
                    end
                    ST_WAIT: begin
                        if (w_strobe_off) begin
                            r_state <= ST_IDLE;
                        end else if (r_cnt == 4'd0) begin
                            r_first <= 1'b1;
                            r_state <= ST_XFER;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    ST_XFER: begin
                        r_first <= 1'b0;
                        if (r_first && r_dir_rd) begin
                            r_dout    <= w_rd_masked;
                            r_dout_en <= 1'b1;
                        end
                        if (w_strobe_off) begin
                            r_dout_en <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign DOUT    = r_dout;
    assign DOUT_EN = r_dout_en;
    assign READY   = w_ready;
    assign ERR     = r_err;

`ifdef BUS_MEM_PARITY_EN
    logic [BYTES-1:0] r_par [DEPTH];
    logic             r_perr;
    logic [BYTES-1:0] w_din_par;
    logic [BYTES-1:0] w_par_bad;

    function automatic logic [BYTES-1:0] lane_parity(input logic [DATA_W-1:0] d);
        logic [BYTES-1:0] p;
        p = {BYTES{1'b0}};
        for (int i = 0; i < BYTES; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

    assign w_din_par = lane_parity(DIN);
    assign w_par_bad = (r_par[w_idx] ^ lane_parity(w_rdata)) & ~r_be_n;

    // Parity bits follow the data lanes they protect
    always_ff @(posedge CLK) begin
        if (w_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (!r_be_n[i]) begin
                    r_par[w_idx][i] <= w_din_par[i];
                end
            end
        end
    end

    // One-cycle mismatch pulse alongside the read data load
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_perr <= 1'b0;
        end else if ((r_state == ST_XFER) && r_first && r_dir_rd && !ALE) begin
            r_perr <= |w_par_bad;
        end else begin
            r_perr <= 1'b0;
        end
    end

    assign PERR = r_perr;
`endif

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench: three slaves (WAIT_STATES 1, 0, 3) share one bus; a word model and a read scoreboard
// supply every expected value.
`timescale 1ns/1ps
module tb_bus_mem_slave;
    localparam int WS [3] = '{1, 0, 3};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ale;
    logic [19:0] address;
    logic        iom;
    logic [1:0]  be_n;
    logic        rd_n;
    logic        wr_n;
    logic [15:0] din;
    logic [15:0] dout    [3];
    logic        dout_en [3];
    logic        ready   [3];
    logic        err     [3];
    logic        perr    [3];

    int          n_vec = 0;
    int          n_err = 0;
    int          perr_cnt = 0;
    logic [15:0] sb_q [$];
    logic [15:0] model [int];
    logic [19:0] cur_addr;
    logic [1:0]  cur_be;
    logic        cur_iom;

    always #5 clk = ~clk;

    bus_mem_slave #(.WAIT_STATES(1)) dut_ws1 (
        .CLK(clk), .RESET_N(rst_n), .ALE(ale), .ADDRESS(address), .IOM(iom), .BE_N(be_n),
        .RD_N(rd_n), .WR_N(wr_n), .DIN(din), .DOUT(dout[0]), .DOUT_EN(dout_en[0]), .READY(ready[0]),
`ifdef BUS_MEM_PARITY_EN
        .PERR(perr[0]),
`endif
        .ERR(err[0]));

    bus_mem_slave #(.WAIT_STATES(0)) dut_ws0 (
        .CLK(clk), .RESET_N(rst_n), .ALE(ale), .ADDRESS(address), .IOM(iom), .BE_N(be_n),
        .RD_N(rd_n), .WR_N(wr_n), .DIN(din), .DOUT(dout[1]), .DOUT_EN(dout_en[1]), .READY(ready[1]),
`ifdef BUS_MEM_PARITY_EN
        .PERR(perr[1]),
`endif
        .ERR(err[1]));

    bus_mem_slave #(.WAIT_STATES(3)) dut_ws3 (
        .CLK(clk), .RESET_N(rst_n), .ALE(ale), .ADDRESS(address), .IOM(iom), .BE_N(be_n),
        .RD_N(rd_n), .WR_N(wr_n), .DIN(din), .DOUT(dout[2]), .DOUT_EN(dout_en[2]), .READY(ready[2]),
`ifdef BUS_MEM_PARITY_EN
        .PERR(perr[2]),
`endif
        .ERR(err[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_cycle(input logic [19:0] a, input logic [1:0] b, input logic io);
        @(negedge clk);
        ale = 1'b1; address = a; be_n = b; iom = io; rd_n = 1'b1; wr_n = 1'b1;
        cur_addr = a; cur_be = b; cur_iom = io;
    endtask

    // Strobe phase of a cycle already started: ADDR sample, six held cycles, release
    task automatic run_strobe(input bit rd, input logic [15:0] wd, input string tag);
        bit          sel;
        int          idx;
        logic [15:0] word;
        logic [15:0] expv;
        int          lowcnt [3];
        int          first  [3];
        sel  = !cur_iom && (cur_addr < 20'd2048);
        idx  = int'(cur_addr[19:1]);
        word = model.exists(idx) ? model[idx] : 16'h0000;
        expv = 16'h0000;
        for (int i = 0; i < 2; i++) expv[8*i +: 8] = cur_be[i] ? 8'h00 : word[8*i +: 8];
        if (rd && sel) sb_q.push_back(expv);
        @(negedge clk);
        ale = 1'b0; din = wd;
        if (rd) rd_n = 1'b0; else wr_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk({tag, "/addr_ready"}, 32'(ready[d]), (sel && WS[d] > 0) ? 32'd0 : 32'd1);
            lowcnt[d] = 0;
            first[d]  = -1;
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                if (!ready[d]) lowcnt[d]++;
                if (dout_en[d] && first[d] < 0) begin
                    first[d] = k;
                    if (d != 0) chk({tag, "/dout"}, 32'(dout[d]), 32'(expv));
                    else if (sb_q.size() == 0) chk({tag, "/sb_underflow"}, 32'(sb_q.size()), 32'd1);
                    else chk({tag, "/dout"}, 32'(dout[0]), 32'(sb_q.pop_front()));
                end else if (dout_en[d]) begin
                    chk({tag, "/dout_hold"}, 32'(dout[d]), 32'(expv));
                end
`ifdef BUS_MEM_PARITY_EN
                if (d == 0 && perr[0]) perr_cnt++;
`endif
            end
        end
        for (int d = 0; d < 3; d++) begin
            chk({tag, "/ready_low"}, 32'(lowcnt[d]), sel ? 32'(WS[d]) : 32'd0);
            chk({tag, "/latency"}, 32'(first[d]), (rd && sel) ? 32'(WS[d] + 1) : 32'hFFFF_FFFF);
        end
        if (!rd && sel) begin
            for (int i = 0; i < 2; i++) if (!cur_be[i]) word[8*i +: 8] = wd[8*i +: 8];
            model[idx] = word;
        end
        @(negedge clk);
        rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk); #1;
        chk({tag, "/dout_en_off"}, 32'(dout_en[0]), 32'd0);
    endtask

    task automatic bus_wr(input logic [19:0] a, input logic [1:0] b, input logic io,
                          input logic [15:0] d, input string tag);
        start_cycle(a, b, io);
        run_strobe(1'b0, d, tag);
    endtask

    task automatic bus_rd(input logic [19:0] a, input logic [1:0] b, input logic io, input string tag);
        start_cycle(a, b, io);
        run_strobe(1'b1, 16'h0000, tag);
    endtask

    initial begin
        rst_n = 1'b0; ale = 1'b0; address = 20'h00000; iom = 1'b0; be_n = 2'b11;
        rd_n = 1'b1; wr_n = 1'b1; din = 16'h0000;
        cur_addr = 20'h00000; cur_be = 2'b11; cur_iom = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset/ready", 32'(ready[d]), 32'd1);
            chk("reset/dout_en", 32'(dout_en[d]), 32'd0);
            chk("reset/err", 32'(err[d]), 32'd0);
            chk("reset/dout", 32'(dout[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        bus_wr(20'h00010, 2'b00, 1'b0, 16'hA5C3, "wr_a5c3");
        bus_rd(20'h00010, 2'b00, 1'b0, "rd_a5c3");

        bus_wr(20'h00040, 2'b00, 1'b0, 16'hFFFF, "wr_ffff");
        bus_wr(20'h00040, 2'b10, 1'b0, 16'h1234, "wr_lane0");
        bus_rd(20'h00040, 2'b00, 1'b0, "rd_ff34");
        bus_rd(20'h00040, 2'b01, 1'b0, "rd_ff00");

        // Out-of-window and I/O cycles must leave the array untouched
        bus_wr(20'h00000, 2'b00, 1'b0, 16'h7777, "wr_base");
        bus_wr(20'h00010, 2'b00, 1'b1, 16'hDEAD, "wr_io");
        bus_wr(20'h00800, 2'b00, 1'b0, 16'hDEAD, "wr_outside");
        bus_rd(20'h00010, 2'b00, 1'b1, "rd_io");
        bus_rd(20'h00010, 2'b00, 1'b0, "rd_after_io");
        bus_rd(20'h00000, 2'b00, 1'b0, "rd_after_outside");

        bus_wr(20'h00050, 2'b00, 1'b0, 16'h0F0F, "wr_0f0f");
        start_cycle(20'h00050, 2'b00, 1'b0);
        @(negedge clk);
        ale = 1'b0; rd_n = 1'b0; wr_n = 1'b0; din = 16'hBEEF;
        @(negedge clk); #1;
        for (int d = 0; d < 3; d++) chk("err/pulse", 32'(err[d]), 32'd1);
        rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk); #1;
        chk("err/clear", 32'(err[0]), 32'd0);
        bus_rd(20'h00050, 2'b00, 1'b0, "rd_after_err");

        bus_wr(20'h00020, 2'b00, 1'b0, 16'h3333, "wr_3333");
        start_cycle(20'h00020, 2'b00, 1'b0);
        @(negedge clk);
        ale = 1'b0; wr_n = 1'b0; din = 16'h4444;
        start_cycle(20'h00022, 2'b00, 1'b0);
        run_strobe(1'b0, 16'h5555, "wr_restart");
        bus_rd(20'h00020, 2'b00, 1'b0, "rd_old_loc");
        bus_rd(20'h00022, 2'b00, 1'b0, "rd_new_loc");

        bus_wr(20'h00030, 2'b00, 1'b0, 16'h1111, "wr_1111");
        start_cycle(20'h00030, 2'b00, 1'b0);
        @(negedge clk);
        ale = 1'b0; wr_n = 1'b0; din = 16'h2222;
        @(negedge clk); #1;
        chk("rst/in_wait", 32'(ready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst/ready", 32'(ready[d]), 32'd1);
            chk("rst/dout_en", 32'(dout_en[d]), 32'd0);
            chk("rst/err", 32'(err[d]), 32'd0);
        end
        @(negedge clk);
        wr_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(20'h00030, 2'b00, 1'b0, "rd_after_rst");

`ifdef BUS_MEM_PARITY_EN
        bus_wr(20'h00060, 2'b00, 1'b0, 16'h00FF, "wr_par");
        perr_cnt = 0;
        bus_rd(20'h00060, 2'b00, 1'b0, "rd_par_clean");
        chk("perr/clean", 32'(perr_cnt), 32'd0);
        dut_ws1.r_par[16'h30][0] = ~dut_ws1.r_par[16'h30][0];
        perr_cnt = 0;
        bus_rd(20'h00060, 2'b00, 1'b0, "rd_par_flip");
        chk("perr/flip", 32'(perr_cnt), 32'd1);
`endif

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
